// File: rtl/noc_injection_scheduler_pkg.sv
// Shared types for the per-node injection scheduler: packet format and FSM state encoding.
package noc_injection_scheduler_pkg;

   localparam int unsigned N       = 4;
   localparam int unsigned M       = 4;
   localparam int unsigned NODES   = N * M;
   // Packet carries source and destination node ids plus a 24-bit payload.
   localparam int unsigned PKT_W   = 2 * $clog2(NODES) + 24;

   typedef logic [PKT_W-1:0] packet_t;

   typedef enum logic [1:0] {
      StIdle,
      StHold,
      StGap
   } state_t;

endpackage

// File: rtl/noc_injection_scheduler_if.sv
// Source-side and network-side signals of one node's injection scheduler.
interface noc_injection_scheduler_if
   import noc_injection_scheduler_pkg::*;
#(
   parameter int unsigned REQ   = 4,
   parameter int unsigned GAP_W = 4,
   parameter int unsigned CNT_W = 16
) ();

   logic [REQ-1:0]   i_req;
   packet_t          i_pkt [REQ];
   logic [REQ-1:0]   o_grant;
   logic             i_net_en;
   packet_t          o_data;
   logic             o_data_val;
   logic [GAP_W-1:0] i_gap;
   logic [CNT_W-1:0] o_inj_count;
   logic             o_busy;

   modport master (
      output i_req, i_pkt, i_net_en, i_gap,
      input  o_grant, o_data, o_data_val, o_inj_count, o_busy
   );

   modport slave (
      input  i_req, i_pkt, i_net_en, i_gap,
      output o_grant, o_data, o_data_val, o_inj_count, o_busy
   );

endinterface

// File: rtl/noc_injection_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request after ptr (with wrap) wins.
module noc_injection_scheduler_rr_arbiter #(
   parameter int unsigned REQ   = 4,
   parameter int unsigned PTR_W = (REQ > 1) ? $clog2(REQ) : 1
) (
   input  logic [REQ-1:0]   req,
   input  logic [PTR_W-1:0] ptr,
   output logic [REQ-1:0]   grant,
   output logic             valid,
   output logic [PTR_W-1:0] idx
);

   logic [PTR_W-1:0] cand;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int unsigned i = 1; i <= REQ; i++) begin
         cand = PTR_W'((32'(ptr) + i) % REQ);
         if (!valid && req[cand]) begin
            valid       = 1'b1;
            idx         = cand;
            grant[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/noc_injection_scheduler.sv
// Per-node injection controller: round-robin source selection, hold-until-accept,
// programmable post-injection idle gap and a saturating injection counter.
module noc_injection_scheduler
   import noc_injection_scheduler_pkg::*;
#(
   parameter int unsigned REQ   = 4,
   parameter int unsigned GAP_W = 4,
   parameter int unsigned CNT_W = 16
) (
   input logic                      clk,
   input logic                      reset,
   noc_injection_scheduler_if.slave bus
);

   localparam int unsigned PTR_W = (REQ > 1) ? $clog2(REQ) : 1;

   state_t           state_q, state_d;
   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] win_idx;
   logic [REQ-1:0]   win_grant;
   logic             win_valid;
   logic [REQ-1:0]   grant_q;
   packet_t          data_q;
   logic [GAP_W-1:0] gap_q;
   logic [GAP_W-1:0] gap_cnt_q;
   logic [CNT_W-1:0] count_q;
   logic             capture;
   logic             accept;

   noc_injection_scheduler_rr_arbiter #(
      .REQ   (REQ),
      .PTR_W (PTR_W)
   ) u_arb (
      .req   (bus.i_req),
      .ptr   (ptr_q),
      .grant (win_grant),
      .valid (win_valid),
      .idx   (win_idx)
   );

   assign capture = (state_q == StIdle) && win_valid;
   assign accept  = (state_q == StHold) && bus.i_net_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (win_valid) state_d = StHold;
         StHold: if (bus.i_net_en) state_d = (gap_q == '0) ? StIdle : StGap;
         StGap:  if (gap_cnt_q == GAP_W'(1)) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Datapath: capture on arbitration win, count on accept, count down the idle gap.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q     <= PTR_W'(REQ - 1);
         grant_q   <= '0;
         data_q    <= '0;
         gap_q     <= '0;
         gap_cnt_q <= '0;
         count_q   <= '0;
      end else begin
         grant_q <= '0;
         if (capture) begin
            ptr_q   <= win_idx;
            grant_q <= win_grant;
            data_q  <= bus.i_pkt[win_idx];
            gap_q   <= bus.i_gap;
         end
         if (accept) begin
            gap_cnt_q <= gap_q;
            if (count_q != '1) count_q <= count_q + 1'b1;
         end else if (state_q == StGap) begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
         end
      end
   end

   always_comb begin
      bus.o_data_val  = (state_q == StHold);
      bus.o_busy      = (state_q != StIdle);
      bus.o_grant     = grant_q;
      bus.o_data      = data_q;
      bus.o_inj_count = count_q;
   end

endmodule

// File: tb/tb_noc_injection_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a transaction model.
module tb_noc_injection_scheduler;
   import noc_injection_scheduler_pkg::*;

   localparam int unsigned REQ   = 4;
   localparam int unsigned GAP_W = 4;
   localparam int unsigned CNT_W = 16;

   logic clk;
   logic reset;
   logic reset2;

   int checks;
   int errors;

   noc_injection_scheduler_if #(.REQ(REQ), .GAP_W(GAP_W), .CNT_W(CNT_W)) bus ();
   noc_injection_scheduler_if #(.REQ(REQ), .GAP_W(GAP_W), .CNT_W(4))     bus2 ();

   noc_injection_scheduler #(.REQ(REQ), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   noc_injection_scheduler #(.REQ(REQ), .GAP_W(GAP_W), .CNT_W(4)) dut_sat (
      .clk   (clk),
      .reset (reset2),
      .bus   (bus2)
   );

   always #5 clk = ~clk;

   // Transaction-level model: a held packet, a countdown of idle cycles, last winner.
   bit          m_valid;
   bit          m_first;
   int          m_src;
   int          m_last;
   int          m_cool;
   int          m_gap;
   packet_t     m_data;
   logic [15:0] m_count;

   task automatic model_step();
      bit found;
      int s;
      if (reset) begin
         m_valid = 0; m_first = 0; m_cool = 0; m_gap = 0;
         m_last = REQ - 1; m_count = '0; m_data = '0;
      end else begin
         m_first = 0;
         if (m_valid) begin
            if (bus.i_net_en) begin
               m_valid = 0;
               m_cool  = m_gap;
               if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
            end
         end else if (m_cool > 0) begin
            m_cool = m_cool - 1;
         end else begin
            found = 0;
            for (int k = 1; k <= REQ; k++) begin
               s = (m_last + k) % REQ;
               if (!found && bus.i_req[s]) begin
                  found = 1;
                  m_src = s;
               end
            end
            if (found) begin
               m_valid = 1;
               m_first = 1;
               m_data  = bus.i_pkt[m_src];
               m_gap   = int'(bus.i_gap);
               m_last  = m_src;
            end
         end
      end
   endtask

   task automatic adv();
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.i_req = '0;
      adv();
      adv();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.i_req = '1;
      bus.i_net_en = 1'b1;
      for (int k = 0; k < REQ; k++) bus.i_pkt[k] = packet_t'($urandom());
      for (int c = 0; c < 3; c++) begin
         adv();
         checks += 5;
         if (bus.o_data_val !== 1'b0) begin
            errors++; $display("FAIL reset_val got %0b exp 0", bus.o_data_val);
         end
         if (bus.o_grant !== 4'b0000) begin
            errors++; $display("FAIL reset_grant got %0h exp 0", bus.o_grant);
         end
         if (bus.o_inj_count !== 16'd0) begin
            errors++; $display("FAIL reset_count got %0d exp 0", bus.o_inj_count);
         end
         if (bus.o_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %0b exp 0", bus.o_busy);
         end
         if (bus.o_data !== packet_t'(0)) begin
            errors++; $display("FAIL reset_data got %0h exp 0", bus.o_data);
         end
      end
      bus.i_req = '0;
      reset = 1'b0;
      adv();
   endtask

   task automatic test_single();
      packet_t exp;
      do_reset();
      bus.i_pkt[0] = packet_t'($urandom());
      exp = bus.i_pkt[0];
      bus.i_req = 4'b0001; bus.i_gap = '0; bus.i_net_en = 1'b1;
      adv();
      checks += 3;
      if (bus.o_grant !== 4'b0001) begin
         errors++; $display("FAIL single_grant got %0h exp 1", bus.o_grant);
      end
      if (bus.o_data_val !== 1'b1) begin
         errors++; $display("FAIL single_val got %0b exp 1", bus.o_data_val);
      end
      if (bus.o_data !== exp) begin
         errors++; $display("FAIL single_data got %0h exp %0h", bus.o_data, exp);
      end
      bus.i_req = '0;
      adv();
      checks += 3;
      if (bus.o_data_val !== 1'b0) begin
         errors++; $display("FAIL single_val_t2 got %0b exp 0", bus.o_data_val);
      end
      if (bus.o_grant !== 4'b0000) begin
         errors++; $display("FAIL single_grant_t2 got %0h exp 0", bus.o_grant);
      end
      if (bus.o_inj_count !== 16'd1) begin
         errors++; $display("FAIL single_count got %0d exp 1", bus.o_inj_count);
      end
   endtask

   task automatic test_backpressure();
      packet_t a;
      int grants;
      do_reset();
      a = packet_t'($urandom());
      bus.i_pkt[0] = a;
      bus.i_req = 4'b0001; bus.i_gap = '0; bus.i_net_en = 1'b0;
      adv();
      bus.i_req = '0;
      grants = 0;
      for (int i = 0; i < 6; i++) begin
         checks += 3;
         if (bus.o_grant != 4'b0000) grants++;
         if (bus.o_data_val !== 1'b1) begin
            errors++; $display("FAIL bp_val cyc %0d got %0b exp 1", i, bus.o_data_val);
         end
         if (bus.o_data !== a) begin
            errors++; $display("FAIL bp_data cyc %0d got %0h exp %0h", i, bus.o_data, a);
         end
         if (bus.o_grant !== ((i == 0) ? 4'b0001 : 4'b0000)) begin
            errors++; $display("FAIL bp_grant cyc %0d got %0h", i, bus.o_grant);
         end
         bus.i_pkt[0] = packet_t'($urandom());
         bus.i_net_en = (i == 5);
         adv();
      end
      checks += 3;
      if (bus.o_data_val !== 1'b0) begin
         errors++; $display("FAIL bp_val_end got %0b exp 0", bus.o_data_val);
      end
      if (bus.o_inj_count !== 16'd1) begin
         errors++; $display("FAIL bp_count got %0d exp 1", bus.o_inj_count);
      end
      if (grants != 1) begin
         errors++; $display("FAIL bp_grants got %0d exp 1", grants);
      end
   endtask

   task automatic test_fairness();
      logic [3:0] exp;
      do_reset();
      bus.i_req = '1; bus.i_gap = '0; bus.i_net_en = 1'b1;
      adv();
      for (int i = 0; i < 10; i++) begin
         exp = '0;
         if (i % 2 == 0) exp[(i / 2) % REQ] = 1'b1;
         checks += 2;
         if (bus.o_grant !== exp) begin
            errors++; $display("FAIL fair_grant cyc %0d got %0h exp %0h", i, bus.o_grant, exp);
         end
         if (bus.o_data_val !== (i % 2 == 0)) begin
            errors++; $display("FAIL fair_val cyc %0d got %0b", i, bus.o_data_val);
         end
         adv();
      end
      bus.i_req = '0;
      adv();
      adv();
   endtask

   task automatic test_gap();
      bit ev, eb;
      do_reset();
      bus.i_req = 4'b0001; bus.i_gap = 4'd3; bus.i_net_en = 1'b1;
      adv();
      for (int i = 0; i < 15; i++) begin
         ev = (i == 0) || (i >= 5 && (i - 5) % 3 == 0);
         eb = !((i == 4) || (i >= 7 && (i - 7) % 3 == 0));
         checks += 2;
         if (bus.o_data_val !== ev) begin
            errors++; $display("FAIL gap_val cyc %0d got %0b exp %0b", i, bus.o_data_val, ev);
         end
         if (bus.o_busy !== eb) begin
            errors++; $display("FAIL gap_busy cyc %0d got %0b exp %0b", i, bus.o_busy, eb);
         end
         if (i == 2) bus.i_gap = 4'd1;
         adv();
      end
      bus.i_req = '0; bus.i_gap = '0;
      for (int c = 0; c < 4; c++) adv();
   endtask

   task automatic test_reset_mid_hold();
      do_reset();
      bus.i_req = 4'b0001; bus.i_gap = '0; bus.i_net_en = 1'b1;
      adv();
      bus.i_req = '0;
      adv();
      checks++;
      if (bus.o_inj_count !== 16'd1) begin
         errors++; $display("FAIL rmh_pre_count got %0d exp 1", bus.o_inj_count);
      end
      bus.i_req = 4'b0001; bus.i_net_en = 1'b0;
      adv();
      checks++;
      if (bus.o_data_val !== 1'b1) begin
         errors++; $display("FAIL rmh_hold got %0b exp 1", bus.o_data_val);
      end
      reset = 1'b1; bus.i_req = 4'b0101;
      adv();
      checks += 3;
      if (bus.o_data_val !== 1'b0) begin
         errors++; $display("FAIL rmh_val got %0b exp 0", bus.o_data_val);
      end
      if (bus.o_inj_count !== 16'd0) begin
         errors++; $display("FAIL rmh_count got %0d exp 0", bus.o_inj_count);
      end
      if (bus.o_grant !== 4'b0000) begin
         errors++; $display("FAIL rmh_grant got %0h exp 0", bus.o_grant);
      end
      reset = 1'b0;
      adv();
      checks++;
      if (bus.o_grant !== 4'b0001) begin
         errors++; $display("FAIL rmh_first got %0h exp 1", bus.o_grant);
      end
      bus.i_req = '0; bus.i_net_en = 1'b1;
      adv();
      adv();
   endtask

   task automatic test_saturate();
      reset2 = 1'b1;
      bus2.i_req = '0;
      adv();
      adv();
      reset2 = 1'b0;
      bus2.i_req = 4'b0001; bus2.i_net_en = 1'b1; bus2.i_gap = '0;
      for (int c = 1; c <= 34; c++) begin
         adv();
         if (c == 28) begin
            checks++;
            if (bus2.o_inj_count !== 4'd14) begin
               errors++; $display("FAIL sat_28 got %0d exp 14", bus2.o_inj_count);
            end
         end
         if (c == 30 || c == 34) begin
            checks++;
            if (bus2.o_inj_count !== 4'd15) begin
               errors++; $display("FAIL sat_%0d got %0d exp 15", c, bus2.o_inj_count);
            end
         end
      end
      bus2.i_req = '0;
   endtask

   task automatic test_random();
      logic [3:0] eg;
      do_reset();
      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 63) == 0);
         bus.i_req = 4'($urandom());
         for (int k = 0; k < REQ; k++) bus.i_pkt[k] = packet_t'($urandom());
         bus.i_net_en = ($urandom_range(0, 2) != 0);
         bus.i_gap = 4'($urandom_range(0, 3));
         adv();
         eg = '0;
         if (m_first) eg[m_src] = 1'b1;
         checks += 5;
         if (bus.o_data_val !== m_valid) begin
            errors++; $display("FAIL rnd_val cyc %0d got %0b exp %0b", n, bus.o_data_val, m_valid);
         end
         if (bus.o_grant !== eg) begin
            errors++; $display("FAIL rnd_grant cyc %0d got %0h exp %0h", n, bus.o_grant, eg);
         end
         if (bus.o_busy !== (m_valid || m_cool > 0)) begin
            errors++; $display("FAIL rnd_busy cyc %0d got %0b", n, bus.o_busy);
         end
         if (bus.o_inj_count !== m_count) begin
            errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", n, bus.o_inj_count, m_count);
         end
         if (!$onehot0(bus.o_grant) || (bus.o_grant != 0 && !bus.o_data_val)) begin
            errors++; $display("FAIL rnd_onehot cyc %0d got %0h val %0b", n, bus.o_grant,
                               bus.o_data_val);
         end
         if (m_valid) begin
            checks++;
            if (bus.o_data !== m_data) begin
               errors++; $display("FAIL rnd_data cyc %0d got %0h exp %0h", n, bus.o_data, m_data);
            end
         end
      end
      reset = 1'b0;
   endtask

   initial begin
      clk = 1'b0;
      checks = 0;
      errors = 0;
      reset = 1'b1;
      reset2 = 1'b1;
      bus.i_req = '0; bus.i_net_en = 1'b0; bus.i_gap = '0;
      bus2.i_req = '0; bus2.i_net_en = 1'b0; bus2.i_gap = '0;
      for (int k = 0; k < REQ; k++) begin
         bus.i_pkt[k] = '0;
         bus2.i_pkt[k] = packet_t'($urandom());
      end
      @(negedge clk);
      test_reset();
      test_single();
      test_backpressure();
      test_fairness();
      test_gap();
      test_reset_mid_hold();
      test_saturate();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/noc_injection_scheduler.md
Name: noc_injection_scheduler

Overview:
- Per-node injection controller between up to REQ local packet sources and one network injection port (the i_data / i_data_val / o_en triple of one node).
- Round-robin arbitrates among sources, latches the winning packet and holds it valid until the network accepts it.
- Enforces a programmable minimum idle gap between injections and keeps a saturating count of injected packets.

Parameters:
- REQ, 4, number of local requesters (≥2).
- GAP_W, 4, width of the inter-injection gap setting.
- CNT_W, 16, width of the injected-packet counter.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  synchronous, active-high reset.
- i_req  input  REQ  per-source request, held until granted.
- i_pkt  input  REQ x packet_t  per-source packet, stable while i_req is high.
- o_grant  output  REQ  one-hot, one-cycle pulse: packet of that source captured.
- i_net_en  input  1  network ready (network o_en for this node).
- o_data  output  packet_t  packet to network (node's i_data).
- o_data_val  output  1  packet valid (node's i_data_val).
- i_gap  input  GAP_W  minimum idle cycles after each accepted injection, sampled at capture.
- o_inj_count  output  CNT_W  saturating count of accepted injections.
- o_busy  output  1  high when state ≠ IDLE.

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - State = IDLE; o_data_val, o_grant, o_busy, o_inj_count = 0; o_data = 0.
  - RR pointer = REQ-1, so source 0 has first priority.
  - A packet held at reset is dropped with no grant issued.
- IDLE:
  - If any i_req is high, pick the first requester searching from pointer+1 with wrap-around.
  - Capture i_pkt[g] into the output register, latch i_gap, set pointer = g, go to HOLD.
  - Otherwise remain in IDLE.
- HOLD:
  - o_data_val = 1, o_data = captured packet, stable regardless of i_pkt changes.
  - o_grant[g] pulses high in the first HOLD cycle only.
  - Accept occurs in any HOLD cycle with i_net_en = 1. On accept, o_inj_count increments (saturating at all-ones).
  - After accept: go to IDLE if the latched gap = 0; otherwise load the gap counter with the latched gap and go to GAP.
  - Without accept: remain in HOLD indefinitely.
- GAP:
  - o_data_val = 0.
  - Counter decrements each cycle; go to IDLE in the cycle the counter reaches 1.
- i_net_en is ignored outside HOLD.
- i_req changes during HOLD/GAP have no effect until the next IDLE.
- Sources must drop i_req, or present the next packet, by the cycle after o_grant. The earliest re-sample of i_req is 1 cycle after accept, which is consistent with this rule.
- Throughput:
  - Gap 0 with i_net_en held high gives one packet per 2 cycles (IDLE, HOLD).
  - Gap k gives one packet per k+2 cycles.
- Latency: request seen in IDLE at cycle t → o_data_val and o_grant at t+1.
- One-hot invariant: o_grant has at most one bit set, and only when o_data_val = 1.

Decomposition:
- packet_t, NODES, N and M come from the shared config package.
- Add state_t (IDLE, HOLD, GAP) to the same package.
- One natural sub-module: rr_arbiter. It is combinational, taking REQ request bits and a pointer and returning a one-hot grant plus a valid flag; it is reusable by the switch allocator.

Test Plan:
- Reset: assert reset 3 cycles with all i_req high → o_data_val = 0, o_grant = 0, o_inj_count = 0, o_busy = 0 throughout.
- Single source: i_req = 0001 at t0, i_gap = 0, i_net_en = 1 → o_grant = 0001 and o_data_val = 1 at t1 only, o_data = i_pkt[0], o_inj_count = 1 at t2.
- Backpressure: i_net_en = 0 for 5 cycles then 1 → o_data_val high 6 cycles with o_data unchanged while i_pkt[0] is altered; one grant; count +1.
- Fairness: i_req = 1111 held, i_gap = 0, i_net_en = 1 → grants in order 0, 1, 2, 3, 0 at 2-cycle spacing.
- Gap: i_gap = 3, i_req = 0001 held, i_net_en = 1 → o_data_val pulses every 5 cycles; changing i_gap mid-GAP affects only the next packet.
- Reset mid-HOLD:
  - Stimulus: reset in a HOLD cycle with i_net_en = 0.
  - Required: next cycle o_data_val = 0 and count = 0; after release with i_req = 0101, source 0 is granted first.
  - Separately, with CNT_W = 4, 17 accepted packets leave o_inj_count at 15.
